// File: rtl/horizontal_pkg.sv
// rtl/horizontal_pkg.sv - shared state encoding and width defaults for the horizontal write scheduler
package horizontal_pkg;

  localparam int DEF_S_WIDTH  = 4;
  localparam int DEF_DCNT_BP4 = 10;
  localparam int DEF_DC_WIDTH = 13;
  localparam int GROUP_LEN    = 2 ** DEF_S_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/horizontal_grp_cnt.sv
// rtl/horizontal_grp_cnt.sv - phase counter inside a group plus group index
module horizontal_grp_cnt
  import horizontal_pkg::*;
#(
  parameter int S_WIDTH  = DEF_S_WIDTH,
  parameter int DCNT_BP4 = DEF_DCNT_BP4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                inc,
  output logic [S_WIDTH-1:0]  phase,
  output logic [DCNT_BP4-1:0] grp_idx,
  output logic                wrap
);

  assign wrap = inc && (phase == {S_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      grp_idx <= '0;
    end else if (clear) begin
      phase   <= '0;
      grp_idx <= '0;
    end else if (inc) begin
      // phase rolls over to 0 by itself at the end of each group
      phase <= phase + S_WIDTH'(1);
      if (wrap) begin
        grp_idx <= grp_idx + DCNT_BP4'(1);
      end
    end
  end

endmodule

// File: rtl/horizontal_wr_sched.sv
// rtl/horizontal_wr_sched.sv - schedules 16-cycle write groups for the horizontal output datapath
module horizontal_wr_sched
  import horizontal_pkg::*;
#(
  parameter int S_WIDTH  = DEF_S_WIDTH,
  parameter int DCNT_BP4 = DEF_DCNT_BP4,
  parameter int DC_WIDTH = DEF_DC_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DCNT_BP4-1:0] grp_num,
  input  logic                hold,
  output logic                horizontal_en_out,
  output logic [S_WIDTH-1:0]  phase,
  output logic [DC_WIDTH-1:0] rom_waddr,
  output logic                busy,
  output logic                done,
  output logic                err_start
);

  sched_state_t        state;
  sched_state_t        state_nxt;
  logic [DCNT_BP4-1:0] grp_total;
  logic                load_total;
  logic                err_nxt;
  logic                cnt_clear;
  logic                cnt_inc;
  logic                cnt_wrap;
  logic [S_WIDTH-1:0]  cnt_phase;
  logic [DCNT_BP4-1:0] grp_idx;
  logic                last_grp;

  horizontal_grp_cnt #(
    .S_WIDTH  (S_WIDTH),
    .DCNT_BP4 (DCNT_BP4)
  ) u_grp_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .phase   (cnt_phase),
    .grp_idx (grp_idx),
    .wrap    (cnt_wrap)
  );

  assign last_grp = (grp_idx == grp_total - DCNT_BP4'(1));

  always_comb begin
    state_nxt  = state;
    load_total = 1'b0;
    err_nxt    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (grp_num != '0) begin
            load_total = 1'b1;
            cnt_clear  = 1'b1;
            state_nxt  = ST_RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_inc = 1'b1;
        err_nxt = start;
        // frame end wins over a pause request on the last group
        if (cnt_wrap) begin
          if (last_grp) begin
            state_nxt = ST_DONE;
          end else if (hold) begin
            state_nxt = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        err_nxt = start;
        if (!hold) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        err_nxt   = start;
        cnt_clear = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grp_total <= '0;
      err_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_start <= err_nxt;
      if (load_total) begin
        grp_total <= grp_num;
      end
    end
  end

  assign horizontal_en_out = (state == ST_RUN);
  assign busy              = (state != ST_IDLE);
  assign done              = (state == ST_DONE);

  always_comb begin
    phase     = '0;
    rom_waddr = '0;
    if (state == ST_RUN) begin
      phase                      = cnt_phase;
      rom_waddr[DCNT_BP4+1:0]    = {grp_idx, cnt_phase[1:0]};
    end
  end

endmodule

// File: tb/tb_horizontal_wr_sched.sv
// tb/tb_horizontal_wr_sched.sv - self-checking bench for horizontal_wr_sched
module tb_horizontal_wr_sched;
  import horizontal_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  grp_num;
  logic        hold;
  logic        en;
  logic [3:0]  phase;
  logic [12:0] rom_waddr;
  logic        busy;
  logic        done;
  logic        err_start;

  int checks = 0;
  int errors = 0;
  int en_cnt, done_cnt, busy_cnt;
  bit pend_err = 0;

  typedef struct {
    bit start;
    int gn;
    bit hold;
    bit en;
    bit busy;
    bit done;
    bit err;
    int phase;
    int waddr;
  } cyc_t;

  cyc_t q[$];

  horizontal_wr_sched dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .grp_num           (grp_num),
    .hold              (hold),
    .horizontal_en_out (en),
    .phase             (phase),
    .rom_waddr         (rom_waddr),
    .busy              (busy),
    .done              (done),
    .err_start         (err_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected trace entry; err is whatever the previous cycle's start deserved.
  function automatic void push(input bit st, input int gn, input bit h, input bit e, input bit b,
                               input bit d, input int ph, input int wa, input bit idle);
    cyc_t c;
    c.start = st; c.gn = gn; c.hold = h;
    c.en = e; c.busy = b; c.done = d; c.phase = ph; c.waddr = wa;
    c.err = pend_err;
    pend_err = st && (!idle || gn == 0);
    q.push_back(c);
  endfunction

  // A frame is n groups of 16 enabled cycles, with a pause of pl cycles after a
  // non-last group whenever hold is high at that group's phase 15.
  task automatic build_frame(input int n, input bit rnd, input int pg, input int plen,
                             input bit last_hold, input bit bad_start);
    bit last, h, st;
    int pl;
    push(1'b1, n, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    for (int g = 0; g < n; g++) begin
      last = (g == n - 1);
      pl = 0;
      if (!last) begin
        if (g == pg) pl = plen;
        else if (rnd && $urandom_range(2) == 0) pl = 1 + $urandom_range(3);
      end
      for (int k = 0; k < GROUP_LEN; k++) begin
        if (k == GROUP_LEN - 1)
          h = (pl > 0) || (last && (last_hold || (rnd && $urandom_range(1) == 1)));
        else if (g == pg && pl > 0) h = (k >= 9);
        else if (last && last_hold) h = 1'b1;
        else h = rnd ? ($urandom_range(1) == 1) : 1'b0;
        st = (rnd && $urandom_range(7) == 0) || (bad_start && g == 0 && k == 5);
        push(st, rnd ? $urandom_range(7) : n, h, 1, 1, 0, k, g * 4 + k % 4, 1'b0);
      end
      for (int p = 0; p < pl; p++)
        push(rnd && $urandom_range(7) == 0, 0, p < pl - 1, 0, 1, 0, 0, 0, 1'b0);
    end
    push(rnd && $urandom_range(3) == 0, 0, rnd ? ($urandom_range(1) == 1) : 1'b0, 0, 1, 1, 0, 0, 1'b0);
    push(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic play(input int limit);
    cyc_t c;
    int i;
    i = 0;
    while (q.size() > 0 && i < limit) begin
      c = q.pop_front();
      start = c.start; grp_num = 10'(c.gn); hold = c.hold;
      @(negedge clk);
      check("en", en, c.en);
      check("busy", busy, c.busy);
      check("done", done, c.done);
      check("err_start", err_start, c.err);
      check("phase", phase, c.phase);
      check("rom_waddr", rom_waddr, c.waddr);
      en_cnt += int'(en);
      done_cnt += int'(done);
      busy_cnt += int'(busy);
      @(posedge clk);
      #1;
      i++;
    end
    start = 1'b0; hold = 1'b0;
  endtask

  task automatic clear_counts();
    en_cnt = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err_start, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_waddr"}, rom_waddr, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; grp_num = '0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    push(1'b1, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    push(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    push(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    play(100);

    clear_counts();
    build_frame(1, 1'b0, -1, 0, 1'b0, 1'b0);
    play(1000);
    check("single_en_cycles", en_cnt, GROUP_LEN);
    check("single_done", done_cnt, 1);
    check("single_busy", busy_cnt, GROUP_LEN + 1);

    clear_counts();
    build_frame(3, 1'b0, -1, 0, 1'b0, 1'b0);
    play(1000);
    check("multi_en_cycles", en_cnt, 3 * GROUP_LEN);
    check("multi_done", done_cnt, 1);

    clear_counts();
    build_frame(4, 1'b0, 0, 6, 1'b0, 1'b0);
    play(1000);
    check("hold_en_cycles", en_cnt, 4 * GROUP_LEN);
    check("hold_busy", busy_cnt, 4 * GROUP_LEN + 6 + 1);

    clear_counts();
    build_frame(2, 1'b0, -1, 0, 1'b1, 1'b0);
    play(1000);
    check("lasthold_busy", busy_cnt, 2 * GROUP_LEN + 1);

    clear_counts();
    build_frame(2, 1'b0, -1, 0, 1'b0, 1'b1);
    play(1000);
    check("badstart_en_cycles", en_cnt, 2 * GROUP_LEN);

    clear_counts();
    build_frame(2, 1'b0, -1, 0, 1'b0, 1'b0);
    play(1 + GROUP_LEN + 7);
    check("pre_reset_en", en, 1);
    check("pre_reset_phase", phase, 7);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", done, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    pend_err = 0;
    clear_counts();
    build_frame(1, 1'b0, -1, 0, 1'b0, 1'b0);
    play(1000);
    check("post_reset_en_cycles", en_cnt, GROUP_LEN);
    check("post_reset_done", done_cnt, 1);

    for (int f = 0; f < 15; f++) begin
      if ($urandom_range(2) == 0) push(1'b1, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
      build_frame(1 + $urandom_range(4), 1'b1, -1, 0, 1'b0, 1'b0);
    end
    push(1'b0, 0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    play(20000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
